// File: rtl/uart_frame_tx.sv
// Streams one frame from the transmission buffer over an 8N1 UART: two header
// bytes, then every 16-bit word high byte first, with fixed idle gaps between words.
module uart_frame_tx #(
    parameter int          CLKS_PER_BIT = 217,
    parameter int          NUM_WORDS    = 19200,
    parameter logic [7:0]  HDR0         = 8'hAA,
    parameter logic [7:0]  HDR1         = 8'h55
) (
    input  logic        dclk,
    input  logic        clr,
    input  logic        start,
    input  logic [15:0] tmem_dout,
    output logic [14:0] t_addr,
    output logic        tmem_rd_en,
    output logic        txd,
    output logic        busy,
    output logic        frame_done
);

    // state   | meaning
    // IDLE    | line idle, waiting for start
    // HDR_A   | serializing HDR0
    // HDR_B   | serializing HDR1
    // FETCH   | read address presented, read enable high
    // LATCH   | buffer data captured into word register
    // SEND_HI | serializing word[15:8]
    // SEND_LO | serializing word[7:0]
    // NEXT    | advance word index or finish
    // DONE    | frame_done pulse, address returns to 0
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_HDR_A   = 4'd1;
    localparam logic [3:0] S_HDR_B   = 4'd2;
    localparam logic [3:0] S_FETCH   = 4'd3;
    localparam logic [3:0] S_LATCH   = 4'd4;
    localparam logic [3:0] S_SEND_HI = 4'd5;
    localparam logic [3:0] S_SEND_LO = 4'd6;
    localparam logic [3:0] S_NEXT    = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [14:0]     LAST_IDX  = 15'(NUM_WORDS - 1);

    logic [3:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [14:0]   word_idx;
    logic [15:0]   word_q;
    logic [9:0]    shreg;
    logic          sending;
    logic          bit_end;
    logic          byte_end;
    logic          last_word;

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    assign sending   = (state == S_HDR_A) || (state == S_HDR_B) ||
                       (state == S_SEND_HI) || (state == S_SEND_LO);
    assign bit_end   = (baud_cnt == '0);
    assign byte_end  = sending && bit_end && (bit_cnt == 4'd9);
    assign last_word = (word_idx == LAST_IDX);

    // The shift register fills with ones as it drains, so its LSB is the line level
    // in every state and txd comes straight from a flop.
    assign txd        = shreg[0];
    assign tmem_rd_en = (state == S_FETCH);
    assign frame_done = (state == S_DONE);
    assign busy       = (state != S_IDLE) && (state != S_DONE) &&
                        !((state == S_NEXT) && last_word);

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            word_idx <= '0;
            word_q   <= '0;
            t_addr   <= '0;
            shreg    <= '1;
        end else begin
            if (sending) begin
                if (bit_end) begin
                    baud_cnt <= BAUD_LOAD;
                    shreg    <= {1'b1, shreg[9:1]};
                    bit_cnt  <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
                end else begin
                    baud_cnt <= baud_cnt - 1'b1;
                end
            end

            // Byte-chaining loads below override the drain shift on the same edge.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_HDR_A;
                        baud_cnt <= BAUD_LOAD;
                        bit_cnt  <= '0;
                        shreg    <= frame_of(HDR0);
                    end
                end
                S_HDR_A: begin
                    if (byte_end) begin
                        state <= S_HDR_B;
                        shreg <= frame_of(HDR1);
                    end
                end
                S_HDR_B: begin
                    if (byte_end) begin
                        state  <= S_FETCH;
                        t_addr <= word_idx;
                    end
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    word_q   <= tmem_dout;
                    state    <= S_SEND_HI;
                    baud_cnt <= BAUD_LOAD;
                    bit_cnt  <= '0;
                    shreg    <= frame_of(tmem_dout[15:8]);
                end
                S_SEND_HI: begin
                    if (byte_end) begin
                        state <= S_SEND_LO;
                        shreg <= frame_of(word_q[7:0]);
                    end
                end
                S_SEND_LO: begin
                    if (byte_end) state <= S_NEXT;
                end
                S_NEXT: begin
                    if (last_word) begin
                        state <= S_DONE;
                    end else begin
                        word_idx <= word_idx + 15'd1;
                        t_addr   <= word_idx + 15'd1;
                        state    <= S_FETCH;
                    end
                end
                S_DONE: begin
                    t_addr   <= '0;
                    word_idx <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, dclk cycles per UART bit (25 MHz / 115200).
REQ-002 Parameter NUM_WORDS, default 19200, 16-bit words per frame (80 words x 240 rows).
REQ-003 Parameter HDR0, default 8'hAA, first frame-header byte.
REQ-004 Parameter HDR1, default 8'h55, second frame-header byte.
REQ-005 dclk  in  1  pixel clock (25 MHz); all state on rising edge.
REQ-006 clr  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  request one frame transmission; level, sampled in IDLE only.
REQ-008 tmem_dout  in  16  transmission-buffer read data; valid one dclk after address presented.
REQ-009 t_addr  out  15  transmission-buffer read address (also fed to the VGA controller write gate).
REQ-010 tmem_rd_en  out  1  transmission-buffer read-port enable.
REQ-011 txd  out  1  UART serial output, 8N1, idle high.
REQ-012 busy  out  1  high from the first header start bit through the last stop bit.
REQ-013 frame_done  out  1  one-cycle pulse after the final stop bit of a frame.

Function
REQ-014 FSM states SHALL be: IDLE, HDR_A, HDR_B, FETCH, LATCH, SEND_HI, SEND_LO, NEXT, DONE.
REQ-015 IDLE: t_addr=0, tmem_rd_en=0, txd=1, busy=0; on start=1, go to HDR_A next cycle.
REQ-016 HDR_A sends HDR0, then HDR_B sends HDR1, then go to FETCH.
REQ-017 FETCH: drive t_addr=word index, tmem_rd_en=1 for one cycle, then go to LATCH.
REQ-018 LATCH: capture tmem_dout into a 16-bit word register, then go to SEND_HI.
REQ-019 SEND_HI sends word[15:8]; SEND_LO then sends word[7:0]; go to NEXT.
REQ-020 NEXT: if index==NUM_WORDS-1 go to DONE; else increment index, go to FETCH.
REQ-021 DONE: pulse frame_done for one cycle, set t_addr=0, go to IDLE.
REQ-022 t_addr SHALL hold its value between FETCH states; it changes only in FETCH, DONE and reset.
REQ-023 Byte serializer: start bit 0, 8 data bits LSB first, stop bit 1, each held exactly CLKS_PER_BIT cycles.
REQ-024 Each byte therefore occupies 10*CLKS_PER_BIT cycles.
REQ-025 The first start bit SHALL appear on txd 1 cycle after start is sampled high in IDLE.
REQ-026 Inter-byte gap within a header pair or word pair SHALL be 0 cycles.
REQ-027 Word-to-word gap SHALL be exactly 3 cycles at txd=1 (NEXT, FETCH, LATCH).
REQ-028 Header-to-first-word gap SHALL be 2 cycles (FETCH, LATCH).
REQ-029 Baud counter width is clog2(CLKS_PER_BIT); bit counter 4 bits; word index 15 bits.
REQ-030 Counters SHALL never wrap mid-byte; the baud counter reloads at 0 on each bit boundary.
REQ-031 start SHALL be ignored while busy=1; a start held high after DONE SHALL begin a new frame on the cycle after IDLE is re-entered.
REQ-032 NUM_WORDS=1 SHALL send header plus one word, then DONE.
REQ-033 tmem_rd_en SHALL be 0 in every state except FETCH.

Reset
REQ-034 clr=1 SHALL force IDLE immediately (asynchronously) with t_addr=0, tmem_rd_en=0, txd=1, busy=0, frame_done=0, and all counters and the word register cleared.
REQ-035 clr asserted mid-byte SHALL abort the frame with no completion pulse; after release the block waits in IDLE for start.

Verification (CLKS_PER_BIT=4, NUM_WORDS=3 unless stated)
REQ-036 Buffer {16'h1234, 16'hABCD, 16'h00FF}, pulse start -> txd decodes AA 55 12 34 AB CD 00 FF; frame_done pulses once; t_addr sequence 0,1,2, then returns to 0.
REQ-037 Bit timing: each txd bit is held exactly 4 cycles; the first start bit falls 1 cycle after start; the word gap is 3 idle cycles.
REQ-038 start pulsed again during the third byte -> ignored; exactly one frame is sent.
REQ-039 clr asserted during the 5th byte -> txd=1 and busy=0 in the same cycle; no frame_done; a new start sends the full frame from AA.
REQ-040 start held high continuously -> back-to-back frames, each preceded by AA 55, with frame_done once per frame.
REQ-041 NUM_WORDS=1 with word 16'h8001 -> AA 55 80 01, then frame_done; tmem_rd_en high for exactly 1 cycle.
